// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit width, flit type encoding and type decode.
package noc_pkg;

  localparam int unsigned FLIT_W        = 16;
  localparam int unsigned FLIT_TYPE_MSB = 15;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_TYPE_MSB -: 2]);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first request at or after ptr_i.
module noc_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned k;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      k = 32'(ptr_i) + off;
      if (k >= N) k = k - N;
      if (!found && req_i[IDX_W'(k)]) begin
        found                = 1'b1;
        gnt_o[IDX_W'(k)]     = 1'b1;
        idx_o                = IDX_W'(k);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole switch allocator for one output port: round-robin among heads,
// then the port stays locked to the winner until its tail (or a length error).
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN*FLIT_W-1:0] flit_i,
  input  logic                     full_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic                     port_en_o,
  output logic [FLIT_W-1:0]        data_o,
  output logic                     locked_o,
  output logic [2:0]               owner_o,
  output logic                     err_o
);

  localparam int unsigned PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;

  logic [FLIT_W-1:0] flits [NUM_IN];
  logic [NUM_IN-1:0] head_req, bad_req;
  logic [NUM_IN-1:0] arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_any;
  logic [NUM_IN-1:0] grant_c;
  logic [PTR_W-1:0]  sel_idx_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_IN - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Split the flit bus and classify each requester as head-capable or not.
  always_comb begin
    head_req = '0;
    bad_req  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      flits[i] = flit_i[FLIT_W*i +: FLIT_W];
      if (flit_type(flits[i]) == FLIT_HEAD || flit_type(flits[i]) == FLIT_SINGLE)
        head_req[i] = req_i[i];
      else
        bad_req[i]  = req_i[i];
    end
  end

  noc_rr_arbiter #(.N(NUM_IN), .IDX_W(PTR_W)) u_rr_arb (
    .req_i (head_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = 1'b0;
    grant_c   = '0;
    sel_idx_c = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        err_d = |bad_req;
        if (arb_any && !full_i) begin
          grant_c   = arb_gnt;
          sel_idx_c = arb_idx;
          owner_d   = arb_idx;
          if (flit_type(flits[arb_idx]) == FLIT_SINGLE) begin
            rr_ptr_d = ptr_inc(arb_idx);
          end else begin
            state_d   = ST_LOCKED;
            pkt_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (req_i[owner_q]) begin
          unique case (flit_type(flits[owner_q]))
            FLIT_BODY: begin
              if (!full_i) begin
                grant_c = NUM_IN'(1) << owner_q;
                // Overlong packet: accept this flit but drop the lock.
                if (pkt_cnt_q == CNT_W'(MAX_PKT_LEN - 1)) begin
                  err_d     = 1'b1;
                  state_d   = ST_IDLE;
                  rr_ptr_d  = ptr_inc(owner_q);
                  pkt_cnt_d = '0;
                end else begin
                  pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end
              end
            end
            FLIT_TAIL: begin
              if (!full_i) begin
                grant_c   = NUM_IN'(1) << owner_q;
                state_d   = ST_IDLE;
                rr_ptr_d  = ptr_inc(owner_q);
                pkt_cnt_d = '0;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) grant_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign grant_o   = grant_c;
  assign port_en_o = |grant_c;
  assign data_o    = (|grant_c) ? flits[sel_idx_c] : '0;
  assign locked_o  = (state_q == ST_LOCKED);
  assign owner_o   = 3'(owner_q);
  assign err_o     = err_q;

endmodule
